// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter that drives the select of
// the shared 2:1 mux and passes the granted side's valid/ready/data through
// combinationally. A grant lasts at most MAX_BURST accepted beats and is then
// handed to the other side if it is waiting.

module mux2_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [WIDTH-1:0] b_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             sel,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // last: 0 means A was granted most recently, 1 means B
   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          last;
   logic          last_next;
   logic          sel_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          grant_a;
   logic          grant_b;

   // Handshake passthrough; reset blocks every transfer in the same cycle
   assign busy    = (state != IDLE);
   assign m_data  = sel ? b_data : a_data;
   assign a_ready = ~rst & (state == OWN_A) & m_ready;
   assign b_ready = ~rst & (state == OWN_B) & m_ready;
   assign m_valid = ~rst & (((state == OWN_A) & a_valid) | ((state == OWN_B) & b_valid));

   // Next-state: arbitration from IDLE, burst counting and release/handover
   always_comb begin
      state_next = state;
      sel_next   = sel;
      last_next  = last;
      cnt_next   = cnt;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      case (state)
         IDLE: begin
            if (a_valid && b_valid) begin
               if (last) grant_a = 1'b1;
               else      grant_b = 1'b1;
            end else if (a_valid) begin
               grant_a = 1'b1;
            end else if (b_valid) begin
               grant_b = 1'b1;
            end
         end
         OWN_A: begin
            if (!a_valid) begin
               if (b_valid) grant_b = 1'b1;
               else         state_next = IDLE;
            end else if (m_ready) begin
               if (cnt == CNT_LAST) begin
                  if (b_valid) grant_b = 1'b1;
                  else         cnt_next = '0;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
         end
         OWN_B: begin
            if (!b_valid) begin
               if (a_valid) grant_a = 1'b1;
               else         state_next = IDLE;
            end else if (m_ready) begin
               if (cnt == CNT_LAST) begin
                  if (a_valid) grant_a = 1'b1;
                  else         cnt_next = '0;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (grant_a) begin
         state_next = OWN_A;
         sel_next   = 1'b0;
         last_next  = 1'b0;
         cnt_next   = '0;
      end else if (grant_b) begin
         state_next = OWN_B;
         sel_next   = 1'b1;
         last_next  = 1'b1;
         cnt_next   = '0;
      end
   end

   // State registers; last starts at B so A wins the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_next;
         sel   <= sel_next;
         last  <= last_next;
         cnt   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter: directed vectors with a beat scoreboard.
// Expected beats ({sel, data}) are queued by the stimulus and popped by a
// monitor process whenever a downstream handshake occurs.

module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, a_valid1, b_valid1;
   logic [7:0] a_data, b_data;
   logic       m_ready;

   logic       a_ready, b_ready, m_valid, sel, busy;
   logic [7:0] m_data;
   logic       a_ready1, b_ready1, m_valid1, sel1, busy1;
   logic [7:0] m_data1;

   logic [8:0] expQ[$];
   logic [8:0] expQ1[$];

   int asserts = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .sel(sel), .busy(busy)
   );

   mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst),
      .a_valid(a_valid1), .a_ready(a_ready1), .a_data(a_data),
      .b_valid(b_valid1), .b_ready(b_ready1), .b_data(b_data),
      .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
      .sel(sel1), .busy(busy1)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's inputs shortly after the rising edge, then settle
   task automatic applyStimulus(input logic r, input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd, input logic mr);
      rst     = r;
      a_valid = av;
      a_data  = ad;
      b_valid = bv;
      b_data  = bd;
      m_ready = mr;
      #2;
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
         nextCycle();
      end
   endtask

   initial begin
      a_valid1 = 1'b0;
      b_valid1 = 1'b0;

      // Monitor: every accepted downstream beat must match the next queued entry
      fork
         forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
               if (expQ.size() == 0) begin
                  asserts++;
                  failures++;
                  $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", {sel, m_data}, $time);
               end else begin
                  checkOutput("beat", int'({sel, m_data}), int'(expQ.pop_front()));
               end
            end
            if (!rst && m_valid1 && m_ready) begin
               if (expQ1.size() == 0) begin
                  asserts++;
                  failures++;
                  $display("[TB] FAIL unexpected_beat1: got 0x%0h, expected no beat at %0t", {sel1, m_data1}, $time);
               end else begin
                  checkOutput("beat1", int'({sel1, m_data1}), int'(expQ1.pop_front()));
               end
            end
         end
      join_none

      // Reset held with all inputs high
      $display("[TB] reset values");
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b1);
      checkOutput("rst_sel", int'(sel), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_m_valid", int'(m_valid), 0);
      checkOutput("rst_a_ready", int'(a_ready), 0);
      checkOutput("rst_b_ready", int'(b_ready), 0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b0);
      checkOutput("rel_busy", int'(busy), 0);
      checkOutput("rel_m_valid", int'(m_valid), 0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b0);
      checkOutput("first_grant_busy", int'(busy), 1);
      checkOutput("first_grant_sel", int'(sel), 0);
      checkOutput("first_grant_m_valid", int'(m_valid), 1);
      checkOutput("stall_a_ready", int'(a_ready), 0);
      nextCycle();
      idleCycles(2);

      // Single requester A
      $display("[TB] single requester");
      expQ.push_back(9'h011);
      expQ.push_back(9'h022);
      expQ.push_back(9'h033);
      applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
      checkOutput("single_a_ready", int'(a_ready), 1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("single_drop_busy", int'(busy), 1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("single_idle_busy", int'(busy), 0);
      checkOutput("single_idle_sel", int'(sel), 0);
      nextCycle();
      checkOutput("single_drain", expQ.size(), 0);

      // Contention: A was granted last, so B wins first; bursts of 4
      $display("[TB] contention");
      for (int i = 0; i < 4; i++) expQ.push_back(9'h1BB);
      for (int i = 0; i < 4; i++) expQ.push_back(9'h0AA);
      for (int i = 0; i < 4; i++) expQ.push_back(9'h1BB);
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
      nextCycle();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
         if (i == 0) checkOutput("cont_sel_b", int'(sel), 1);
         if (i == 4) checkOutput("cont_sel_a", int'(sel), 0);
         nextCycle();
      end
      idleCycles(2);
      checkOutput("cont_drain", expQ.size(), 0);

      // Stall inside an A burst: count frozen, still 4 beats before handover
      $display("[TB] stall");
      expQ.push_back(9'h041);
      expQ.push_back(9'h042);
      expQ.push_back(9'h043);
      expQ.push_back(9'h044);
      expQ.push_back(9'h151);
      applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 8'h51, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h41, 1'b1, 8'h51, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h42, 1'b1, 8'h51, 1'b1);
      nextCycle();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h43, 1'b1, 8'h51, 1'b0);
         if (i == 4) begin
            checkOutput("stall_a_ready0", int'(a_ready), 0);
            checkOutput("stall_m_valid", int'(m_valid), 1);
            checkOutput("stall_sel", int'(sel), 0);
         end
         nextCycle();
      end
      applyStimulus(1'b0, 1'b1, 8'h43, 1'b1, 8'h51, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h44, 1'b1, 8'h51, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h44, 1'b1, 8'h51, 1'b1);
      checkOutput("handover_sel", int'(sel), 1);
      checkOutput("handover_b_ready", int'(b_ready), 1);
      checkOutput("handover_a_ready", int'(a_ready), 0);
      nextCycle();
      idleCycles(2);
      checkOutput("stall_drain", expQ.size(), 0);

      // Reset asserted on A's second beat
      $display("[TB] reset mid-burst");
      expQ.push_back(9'h061);
      expQ.push_back(9'h062);
      applyStimulus(1'b0, 1'b1, 8'h61, 1'b1, 8'h70, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h61, 1'b1, 8'h70, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 8'h62, 1'b1, 8'h70, 1'b1);
      checkOutput("midrst_a_ready", int'(a_ready), 0);
      checkOutput("midrst_m_valid", int'(m_valid), 0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h62, 1'b1, 8'h70, 1'b1);
      checkOutput("postrst_busy", int'(busy), 0);
      checkOutput("postrst_sel", int'(sel), 0);
      checkOutput("postrst_m_valid", int'(m_valid), 0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h62, 1'b1, 8'h70, 1'b1);
      checkOutput("postrst_grant_sel", int'(sel), 0);
      checkOutput("postrst_grant_busy", int'(busy), 1);
      nextCycle();
      idleCycles(2);
      checkOutput("midrst_drain", expQ.size(), 0);

      // Early release: B drops after one beat, A takes over with no idle cycle
      $display("[TB] early release");
      expQ.push_back(9'h171);
      expQ.push_back(9'h081);
      applyStimulus(1'b0, 1'b1, 8'h81, 1'b1, 8'h71, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h81, 1'b1, 8'h71, 1'b1);
      checkOutput("early_sel_b", int'(sel), 1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h81, 1'b0, 8'h71, 1'b1);
      checkOutput("early_m_valid", int'(m_valid), 0);
      checkOutput("early_a_ready", int'(a_ready), 0);
      checkOutput("early_busy", int'(busy), 1);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 8'h81, 1'b0, 8'h71, 1'b1);
      checkOutput("early_sel_a", int'(sel), 0);
      checkOutput("early_busy_a", int'(busy), 1);
      checkOutput("early_a_ready1", int'(a_ready), 1);
      nextCycle();
      idleCycles(2);
      checkOutput("early_drain", expQ.size(), 0);

      // MAX_BURST = 1: grant alternates every beat
      $display("[TB] max burst 1");
      expQ1.push_back(9'h0AA);
      expQ1.push_back(9'h1BB);
      expQ1.push_back(9'h0AA);
      expQ1.push_back(9'h1BB);
      a_valid1 = 1'b1;
      b_valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 8'hAA, 1'b0, 8'hBB, 1'b1);
         if (i == 2) checkOutput("mb1_sel_b", int'(sel1), 1);
         if (i == 3) checkOutput("mb1_sel_a", int'(sel1), 0);
         nextCycle();
      end
      a_valid1 = 1'b0;
      b_valid1 = 1'b0;
      idleCycles(2);
      checkOutput("mb1_drain", expQ1.size(), 0);
      checkOutput("mb1_busy_idle", int'(busy1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
